// File: rtl/spicart_pkg.sv
// spicart_pkg: shared definitions for the SPI-to-cartridge burst bridge.
//   - header bit positions of the command byte
//   - frame state (header / address / data) and request state enums
//   - addr_bytes(): number of SPI bytes needed to carry an address
package spicart_pkg;

  localparam int HDR_WR_BIT  = 7;
  localparam int HDR_INC_BIT = 6;

  typedef enum logic [1:0] {
    HDR,
    ADDR,
    DATA
  } frame_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_PEND,
    R_WAIT
  } req_state_e;

  function automatic int addr_bytes(input int addr_w);
    return (addr_w + 7) / 8;
  endfunction

endpackage

// File: rtl/spislave.sv
// spislave: byte-framing SPI slave, mode 0 (sample on SCK rise, shift on
// SCK fall), MSB first, chip select active low. SPI pins are oversampled
// in the clk domain through a two-stage synchroniser plus an edge stage.
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   spi_sck_i/mosi_i/cs_i  raw SPI pins from the host
//   spi_miso_o          serial data to the host
//   sdata_i             byte loaded for transmission at each byte boundary
//   data_o              last received byte (valid with data_valid_read_o)
//   data_valid_read_o   one-cycle pulse per received byte
//   data_firstbyte_o    qualifies data_o as first byte after CS assert
//   cs_active_o         synchronised chip-select asserted
module spislave (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sck_i,
  input  logic       spi_mosi_i,
  input  logic       spi_cs_i,
  output logic       spi_miso_o,
  input  logic [7:0] sdata_i,
  output logic [7:0] data_o,
  output logic       data_valid_read_o,
  output logic       data_firstbyte_o,
  output logic       cs_active_o
);

  logic [2:0] sck_q, mosi_q, cs_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] rx_q, tx_q, data_q;
  logic       valid_q, first_q, firstbyte_q;

  logic sck_rise, sck_fall, cs_act, cs_start;
  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign cs_act   = ~cs_q[1];
  assign cs_start = ~cs_q[1] & cs_q[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_q       <= 3'b000;
      mosi_q      <= 3'b000;
      cs_q        <= 3'b111;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      first_q     <= 1'b1;
      firstbyte_q <= 1'b0;
    end else begin
      sck_q   <= {sck_q[1:0], spi_sck_i};
      mosi_q  <= {mosi_q[1:0], spi_mosi_i};
      cs_q    <= {cs_q[1:0], spi_cs_i};
      valid_q <= 1'b0;
      if (!cs_act) begin
        bit_cnt_q <= 3'd0;
        first_q   <= 1'b1;
      end else if (cs_start) begin
        // MSB of the first byte must be on MISO before the first rising edge
        tx_q      <= sdata_i;
        bit_cnt_q <= 3'd0;
      end else if (sck_rise) begin
        rx_q      <= {rx_q[6:0], mosi_q[1]};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          data_q      <= {rx_q[6:0], mosi_q[1]};
          valid_q     <= 1'b1;
          firstbyte_q <= first_q;
          first_q     <= 1'b0;
        end
      end else if (sck_fall) begin
        // bit count back at 0 means the trailing fall of a byte: load next byte
        if (bit_cnt_q == 3'd0) tx_q <= sdata_i;
        else                   tx_q <= {tx_q[6:0], 1'b0};
      end
    end
  end

  assign spi_miso_o        = tx_q[7];
  assign data_o            = data_q;
  assign data_valid_read_o = valid_q;
  assign data_firstbyte_o  = firstbyte_q;
  assign cs_active_o       = cs_act;

endmodule

// File: rtl/spicart_burst.sv
// spicart_burst: SPI-to-cartridge-bus burst bridge.
// A frame is: header byte, ADDR_BYTES address bytes (MSB first), then data
// bytes. Writes post one cart_wr per data byte; reads prefetch after the
// address so each data byte returns the contents of the current address.
// Ports:
//   clk, rst                   system clock, asynchronous active-high reset
//   spi_mosi/sck/cs, spi_miso  SPI link to the host (CS active low)
//   cart_a, cart_dout          registered address / write data
//   cart_din                   read data from the cartridge
//   cart_wr, cart_rd           single-cycle registered access strobes
//   cart_busy                  cartridge not ready; strobes wait while high
//   xfer_active                a request is pending or outstanding
//   err_overrun                sticky: a byte arrived while a request was busy
module spicart_burst
  import spicart_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter bit INC_DEFAULT = 1'b1,
  parameter bit ALLOW_NOINC = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_mosi,
  input  logic              spi_sck,
  input  logic              spi_cs,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] cart_a,
  output logic [7:0]        cart_dout,
  input  logic [7:0]        cart_din,
  output logic              cart_wr,
  output logic              cart_rd,
  input  logic              cart_busy,
  output logic              xfer_active,
  output logic              err_overrun
);

  localparam int ABYTES = addr_bytes(ADDR_W);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_first, cs_active;

  frame_state_e      frame_q;
  req_state_e        req_q;
  logic [ADDR_W-1:0] cart_a_q;
  logic [7:0]        cart_dout_q, rhold_q;
  logic              cart_wr_q, cart_rd_q, xfer_q, err_q;
  logic              wr_mode_q, inc_q, req_wr_q, req_inc_q;
  logic [1:0]        byte_cnt_q;

  spislave u_spislave (
    .clk               (clk),
    .rst               (rst),
    .spi_sck_i         (spi_sck),
    .spi_mosi_i        (spi_mosi),
    .spi_cs_i          (spi_cs),
    .spi_miso_o        (spi_miso),
    .sdata_i           (rhold_q),
    .data_o            (rx_byte),
    .data_valid_read_o (rx_valid),
    .data_firstbyte_o  (rx_first),
    .cs_active_o       (cs_active)
  );

  logic hdr_ev, body_ev, req_idle;
  assign hdr_ev   = rx_valid & rx_first;
  assign body_ev  = rx_valid & ~rx_first;
  assign req_idle = (req_q == R_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q     <= HDR;
      req_q       <= R_IDLE;
      cart_a_q    <= '0;
      cart_dout_q <= 8'h00;
      rhold_q     <= 8'h00;
      cart_wr_q   <= 1'b0;
      cart_rd_q   <= 1'b0;
      xfer_q      <= 1'b0;
      err_q       <= 1'b0;
      wr_mode_q   <= 1'b0;
      inc_q       <= 1'b0;
      req_wr_q    <= 1'b0;
      req_inc_q   <= 1'b0;
      byte_cnt_q  <= 2'd0;
    end else begin
      cart_wr_q <= 1'b0;
      cart_rd_q <= 1'b0;

      // Request FSM
      case (req_q)
        R_PEND: begin
          if (!cart_busy) begin
            if (req_wr_q) cart_wr_q <= 1'b1;
            else          cart_rd_q <= 1'b1;
            req_q <= R_WAIT;
          end
        end
        R_WAIT: begin
          // A strobe still high means this is the strobe cycle itself;
          // completion is only allowed from the following cycle on.
          if (!cart_wr_q && !cart_rd_q && !cart_busy) begin
            if (!req_wr_q)      rhold_q  <= cart_din;
            else if (req_inc_q) cart_a_q <= cart_a_q + ADDR_W'(1);
            req_q  <= R_IDLE;
            xfer_q <= 1'b0;
          end
        end
        default: ;
      endcase

      // Frame FSM
      if (!cs_active) begin
        frame_q <= HDR;
      end else if (hdr_ev) begin
        wr_mode_q  <= rx_byte[HDR_WR_BIT];
        inc_q      <= ALLOW_NOINC ? rx_byte[HDR_INC_BIT] : INC_DEFAULT;
        byte_cnt_q <= 2'd0;
        err_q      <= 1'b0;
        frame_q    <= ADDR;
      end else if (body_ev) begin
        case (frame_q)
          ADDR: begin
            cart_a_q <= {cart_a_q[ADDR_W-9:0], rx_byte};
            if (byte_cnt_q == 2'(ABYTES - 1)) begin
              frame_q <= DATA;
              if (!wr_mode_q) begin
                // prefetch so the first data byte already carries memory data
                if (req_idle) begin
                  req_wr_q <= 1'b0;
                  req_q    <= R_PEND;
                  xfer_q   <= 1'b1;
                end else begin
                  err_q <= 1'b1;
                end
              end
            end else begin
              byte_cnt_q <= byte_cnt_q + 2'd1;
            end
          end
          DATA: begin
            if (!req_idle) begin
              err_q <= 1'b1;
            end else if (wr_mode_q) begin
              cart_dout_q <= rx_byte;
              req_wr_q    <= 1'b1;
              req_inc_q   <= inc_q;
              req_q       <= R_PEND;
              xfer_q      <= 1'b1;
            end else begin
              // read address moves on before the next prefetch is posted
              if (inc_q) cart_a_q <= cart_a_q + ADDR_W'(1);
              req_wr_q <= 1'b0;
              req_q    <= R_PEND;
              xfer_q   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign cart_a      = cart_a_q;
  assign cart_dout   = cart_dout_q;
  assign cart_wr     = cart_wr_q;
  assign cart_rd     = cart_rd_q;
  assign xfer_active = xfer_q;
  assign err_overrun = err_q;

endmodule
